// File: rtl/clap_pkg.sv
// Shared types and constants for the clap detection pipeline.
package clap_pkg;

  // Pipeline controller states.
  typedef enum logic [2:0] {
    StIdle,
    StCal,
    StCalc,
    StRun,
    StHold
  } clap_state_e;

  // Threshold floors used when the measured ambient level is very low.
  localparam int unsigned DEF_MIN_HIGH = 4000;
  localparam int unsigned DEF_MIN_LOW  = 2000;

  // Ceiling log2; value must be >= 1.
  function automatic int unsigned clogb2(input int unsigned value);
    int unsigned v;
    int unsigned r;
    v = value - 1;
    r = 0;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

  // Energy is a sum of squared samples over a window of DURATION samples.
  localparam int unsigned SAMPLE_WIDTH     = 16;
  localparam int unsigned DURATION         = 8;
  localparam int unsigned DEF_ENERGY_WIDTH = 2 * SAMPLE_WIDTH + clogb2(DURATION);

endpackage

// File: rtl/clap_sat_mult.sv
// Constant multiply that saturates to all-ones when the product overflows Width.
module clap_sat_mult #(
  parameter int unsigned Width = 35,
  parameter int unsigned Mult  = 8
) (
  input  logic [Width-1:0] a_i,
  output logic [Width-1:0] p_o
);

  // 32 extra bits hold any product with a 32-bit constant without loss.
  localparam int unsigned ProdW = Width + 32;

  logic [ProdW-1:0] prod;

  // Full-width product, then clamp anything above Width bits.
  always_comb begin
    prod = ProdW'(a_i) * ProdW'(Mult);
    p_o  = (|prod[ProdW-1:Width]) ? '1 : prod[Width-1:0];
  end

endmodule

// File: rtl/clap_pipeline_ctrl.sv
// Sequences the clap detector: ambient calibration, threshold derivation,
// energy pass-through and post-clap holdoff.
module clap_pipeline_ctrl
  import clap_pkg::*;
#(
  parameter int unsigned ENERGY_WIDTH  = DEF_ENERGY_WIDTH,
  parameter int unsigned CAL_LOG2      = 6,
  parameter int unsigned HIGH_MULT     = 8,
  parameter int unsigned LOW_MULT      = 4,
  parameter int unsigned MIN_HIGH      = DEF_MIN_HIGH,
  parameter int unsigned MIN_LOW       = DEF_MIN_LOW,
  parameter int unsigned HOLDOFF_BEATS = 16
) (
  input  logic                    clock,
  input  logic                    resetn,
  input  logic [ENERGY_WIDTH-1:0] energy_data,
  input  logic                    energy_valid,
  output logic                    energy_ready,
  output logic [ENERGY_WIDTH-1:0] det_energy_data,
  output logic                    det_energy_valid,
  input  logic                    det_energy_ready,
  input  logic                    claps_valid,
  input  logic                    claps_ready,
  input  logic                    recal_req,
  output logic [ENERGY_WIDTH-1:0] thr_high,
  output logic [ENERGY_WIDTH-1:0] thr_low,
  output logic                    thr_valid,
  output logic                    busy_cal
);

  localparam int unsigned AccW  = ENERGY_WIDTH + CAL_LOG2;
  localparam int unsigned HoldW = $clog2(HOLDOFF_BEATS + 1);

  localparam logic [ENERGY_WIDTH-1:0] MinHighV = ENERGY_WIDTH'(MIN_HIGH);
  localparam logic [ENERGY_WIDTH-1:0] MinLowV  = ENERGY_WIDTH'(MIN_LOW);
  localparam logic [CAL_LOG2-1:0]     LastBeat = '1;
  localparam logic [HoldW-1:0]        HoldLoad = HoldW'(HOLDOFF_BEATS);
  localparam logic [HoldW-1:0]        HoldOne  = HoldW'(1);

  clap_state_e             state_q, state_d;
  logic [AccW-1:0]         acc_q, acc_d;
  logic [CAL_LOG2-1:0]     cnt_q, cnt_d;
  logic [HoldW-1:0]        hold_q, hold_d;
  logic [ENERGY_WIDTH-1:0] thr_high_q, thr_high_d;
  logic [ENERGY_WIDTH-1:0] thr_low_q, thr_low_d;
  logic                    thr_valid_q, thr_valid_d;
  logic                    pend_q, pend_d;

  logic                    energy_hs;
  logic                    claps_hs;
  logic [ENERGY_WIDTH-1:0] avg;
  logic [ENERGY_WIDTH-1:0] high_prod, low_prod;

  assign energy_hs = energy_valid & energy_ready;
  assign claps_hs  = claps_valid & claps_ready;
  // Truncating divide by the beat count.
  assign avg       = acc_q[AccW-1:CAL_LOG2];

  clap_sat_mult #(
    .Width(ENERGY_WIDTH),
    .Mult (HIGH_MULT)
  ) u_mult_high (
    .a_i(avg),
    .p_o(high_prod)
  );

  clap_sat_mult #(
    .Width(ENERGY_WIDTH),
    .Mult (LOW_MULT)
  ) u_mult_low (
    .a_i(avg),
    .p_o(low_prod)
  );

  assign det_energy_data = energy_data;
  assign thr_high        = thr_high_q;
  assign thr_low         = thr_low_q;
  assign thr_valid       = thr_valid_q;
  assign busy_cal        = (state_q == StIdle) || (state_q == StCal) || (state_q == StCalc);

  // Stream handshake outputs; RUN is a pure combinational pass-through.
  always_comb begin
    energy_ready     = 1'b0;
    det_energy_valid = 1'b0;
    unique case (state_q)
      StCal:  energy_ready = 1'b1;
      StRun: begin
        energy_ready     = det_energy_ready;
        det_energy_valid = energy_valid;
      end
      StHold: energy_ready = 1'b1;
      default: ;
    endcase
  end

  // Next-state logic for the FSM, accumulator, counters and thresholds.
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    hold_d      = hold_q;
    thr_high_d  = thr_high_q;
    thr_low_d   = thr_low_q;
    thr_valid_d = thr_valid_q;
    pend_d      = pend_q;
    unique case (state_q)
      StIdle: state_d = StCal;
      StCal: begin
        if (energy_hs) begin
          acc_d = acc_q + AccW'(energy_data);
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LastBeat) state_d = StCalc;
        end
      end
      StCalc: begin
        thr_high_d  = (high_prod < MinHighV) ? MinHighV : high_prod;
        thr_low_d   = (low_prod < MinLowV) ? MinLowV : low_prod;
        thr_valid_d = 1'b1;
        acc_d       = '0;
        cnt_d       = '0;
        state_d     = StRun;
      end
      StRun: begin
        // A clap takes priority; a simultaneous recal waits until holdoff ends.
        if (claps_hs) begin
          state_d = StHold;
          hold_d  = HoldLoad;
          if (recal_req) pend_d = 1'b1;
        end else if (recal_req || pend_q) begin
          state_d = StCal;
          pend_d  = 1'b0;
        end
      end
      StHold: begin
        if (recal_req) pend_d = 1'b1;
        if (claps_hs) begin
          hold_d = HoldLoad;
        end else if (energy_hs) begin
          hold_d = hold_q - 1'b1;
          if (hold_q == HoldOne) state_d = StRun;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q     <= StIdle;
      acc_q       <= '0;
      cnt_q       <= '0;
      hold_q      <= '0;
      thr_high_q  <= MinHighV;
      thr_low_q   <= MinLowV;
      thr_valid_q <= 1'b0;
      pend_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      hold_q      <= hold_d;
      thr_high_q  <= thr_high_d;
      thr_low_q   <= thr_low_d;
      thr_valid_q <= thr_valid_d;
      pend_q      <= pend_d;
    end
  end

endmodule

// File: doc/clap_pipeline_ctrl.md
# clap_pipeline_ctrl

Controller inserted on the energy stream between the energy computer and the clap detector. It sequences the detection pipeline:
- **Calibrate:** measures ambient energy over a fixed number of energy beats.
- **Configure:** derives the detector's high/low energy thresholds from that measurement.
- **Run:** passes energy through to the detector.
- **Hold off:** discards energy for a programmable number of beats after each clap-count handshake, so one clap cannot re-trigger.

Recalibration is available on request.

## Interface
Parameters:
- ENERGY_WIDTH, 35, width of energy beats and thresholds
- CAL_LOG2, 6, log2 of number of energy beats averaged during calibration (64)
- HIGH_MULT, 8, high threshold = ambient average × HIGH_MULT
- LOW_MULT, 4, low threshold = ambient average × LOW_MULT
- MIN_HIGH, 4000, floor for the high threshold
- MIN_LOW, 2000, floor for the low threshold
- HOLDOFF_BEATS, 16, energy beats discarded after a clap handshake (≥1)

Ports:
- clock  in  1  single clock, all logic rising-edge
- resetn  in  1  asynchronous, active-low reset
- energy_data  in  ENERGY_WIDTH  upstream energy beat
- energy_valid  in  1  upstream valid
- energy_ready  out  1  upstream ready
- det_energy_data  out  ENERGY_WIDTH  to detector; combinational copy of energy_data
- det_energy_valid  out  1  to detector valid
- det_energy_ready  in  1  detector ready
- claps_valid  in  1  snoop of detector→toggler claps handshake
- claps_ready  in  1  snoop of detector→toggler claps handshake
- recal_req  in  1  single-cycle recalibration request
- thr_high  out  ENERGY_WIDTH  high threshold to detector
- thr_low  out  ENERGY_WIDTH  low threshold to detector
- thr_valid  out  1  thresholds derived from at least one calibration
- busy_cal  out  1  high in IDLE, CAL or CALC

## Operation
States: IDLE, CAL, CALC, RUN, HOLD.

State transitions:
- **Reset:** state=IDLE, acc=0, beat count=0, thr_high=MIN_HIGH, thr_low=MIN_LOW, thr_valid=0, recal pending=0.
- **IDLE → CAL:** unconditionally on the next clock.
- **CAL:** energy_ready=1, det_energy_valid=0. Each upstream handshake adds energy_data to acc (width ENERGY_WIDTH+CAL_LOG2, no overflow possible). The 2^CAL_LOG2-th handshake moves the state to CALC.
- **CALC (one cycle):** energy_ready=0, det_energy_valid=0.
  - avg = acc >> CAL_LOG2 (truncating).
  - thr_high = max(avg×HIGH_MULT, MIN_HIGH); thr_low = max(avg×LOW_MULT, MIN_LOW).
  - Each product is computed at full width and saturates to all-ones of ENERGY_WIDTH if it exceeds that width.
  - Sets thr_valid=1, clears acc and the beat count, then moves to RUN.
- **RUN:** energy_ready=det_energy_ready, det_energy_valid=energy_valid, data passes straight through with zero latency.
  - A claps handshake (claps_valid & claps_ready) moves the state to HOLD with holdoff count=HOLDOFF_BEATS.
  - Otherwise, recal_req or recal pending moves the state to CAL and clears the pending flag.
  - If both occur in the same cycle, HOLD wins and recal is latched as pending.
  - An energy beat handshaking in the same cycle as the transition is delivered normally.
- **HOLD:** energy_ready=1, det_energy_valid=0. Upstream beats are consumed and discarded, and each one decrements the holdoff count. The handshake that takes the count to 0 returns the state to RUN.
  - Further claps handshakes in HOLD reload the count to HOLDOFF_BEATS.
  - recal_req in HOLD sets pending, which is honoured on the first RUN cycle.

Other rules:
- recal_req in IDLE, CAL or CALC is ignored; calibration is already in progress.
- During recalibration, thr_high/thr_low keep their previous values until CALC, and thr_valid stays 1.
- Thresholds change only in CALC.

## Timing
- Pass-through latency in RUN: 0 cycles, purely combinational for data, valid and ready.
- Calibration from reset deassertion: 1 IDLE cycle, then 2^CAL_LOG2 beats, then 1 CALC cycle. Thresholds are visible the cycle after CALC.
- All state, counter and threshold registers are flopped; no combinational path from claps_* or recal_req to any output.
- Reset asserted mid-operation clears the state immediately and asynchronously: outputs return to their reset values and any partial accumulation is lost.
- energy_valid must not depend on energy_ready (AXI-stream rule). In RUN the block adds no dependency of its own.

## Structure
- Shared package clap_pkg holds:
  - state enum (IDLE, CAL, CALC, RUN, HOLD)
  - default threshold constants MIN_HIGH/MIN_LOW
  - ENERGY_WIDTH derivation (2×SAMPLE_WIDTH + clogb2(DURATION))
- One natural sub-module: clap_sat_mult, a parameterised constant multiply with saturation to the output width, instantiated twice (high and low). Everything else stays in a single FSM-plus-datapath module.

## Test plan
- **Baseline:** CAL_LOG2=2, four beats of 1000 → thr_high=8000, thr_low=4000, thr_valid=1, RUN entered on the 6th cycle after the first CAL handshake.
- **Floor:** four beats of 100 → thr_high=4000 (floor), thr_low=2000 (floor).
- **Saturation:** four beats of all-ones → thr_high=thr_low=2^ENERGY_WIDTH−1.
- **Holdoff:** in RUN, claps handshake, then 20 beats with HOLDOFF_BEATS=16 → exactly 16 discarded, det_energy_valid=0 during them; beats 17–20 reach the detector unchanged.
- **Collision:** recal_req in the same cycle as a claps handshake → HOLD first, then 16 discards, then CAL on the first RUN cycle; old thresholds held until the new CALC.
- **Reset mid-CAL:** reset after 2 of 4 beats, then four beats of 500 → thresholds 4000 and 2000 (floor-limited), with no contribution from the pre-reset beats; energy_ready=0 during reset and in IDLE.
